// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-ramp path.
// Holds the default widths, the full-scale period count and the ramp FSM state encoding.
package pwm_pkg;

  localparam int unsigned NUM_BIT   = 12;
  localparam int unsigned STEP_BITS = 8;

  // Last count of a PWM period, i.e. 2^NUM_BIT - 1.
  localparam logic [NUM_BIT-1:0] PERIOD_MAX = '1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRamp = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter with a registered end-of-period tick.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   o_tick - high for exactly the clock in which the counter reads all-ones
// Kept separate so the PWM stage can share it and stay phase-aligned with the ramp.
module pwm_period_timer #(
  parameter int unsigned NumBit = 12
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  // Tick is registered, so it is armed one count early to line up with the all-ones count.
  localparam logic [NumBit-1:0] CntPreMax = {{(NumBit - 1){1'b1}}, 1'b0};

  logic [NumBit-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + NumBit'(1);
    tick_d = (cnt_q == CntPreMax);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Rate-limited duty-cycle feeder for the PWM stage.
// Accepts a target/step request over valid/ready and slews the duty cycle toward the
// target by at most one step per PWM period, updating only at period boundaries.
// Ports:
//   i_clk, i_rst  - clock and asynchronous active-high reset
//   i_target      - requested final duty cycle
//   i_step        - maximum change per period; 0 jumps straight to the target
//   i_valid       - request qualifier
//   o_ready       - idle and able to accept a request
//   o_dutyCycle   - registered duty cycle driving the PWM stage
//   o_busy        - ramp in progress
//   o_tick        - one-cycle pulse on the last clock of each PWM period
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned _NUM_BIT   = pwm_pkg::NUM_BIT,
  parameter int unsigned _STEP_BITS = pwm_pkg::STEP_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [_NUM_BIT-1:0]   i_target,
  input  logic [_STEP_BITS-1:0] i_step,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [_NUM_BIT-1:0]   o_dutyCycle,
  output logic                  o_busy,
  output logic                  o_tick
);

  localparam int unsigned NB = _NUM_BIT;
  localparam int unsigned SB = _STEP_BITS;
  // Compare width wide enough for both |diff| and step, whichever is larger.
  localparam int unsigned CmpW = ((SB > NB) ? SB : NB) + 1;

  ramp_state_e   state_q, state_d;
  logic [NB-1:0] target_q, target_d;
  logic [SB-1:0] step_q, step_d;
  logic [NB-1:0] duty_q, duty_d;

  logic          tick;
  logic signed [NB:0] diff;
  logic [NB:0]   abs_diff;
  logic [CmpW-1:0] abs_w, step_w;
  logic [NB-1:0] step_n;
  logic          land;

  pwm_period_timer #(
    .NumBit (NB)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    step_d   = step_q;
    duty_d   = duty_q;

    diff     = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
    abs_diff = diff[NB] ? NB'(0) - diff : diff;
    abs_w    = CmpW'(abs_diff);
    step_w   = CmpW'(step_q);
    // Only used when step < |diff|, so it always fits in NB bits.
    step_n   = NB'(step_q);
    // Landing on target whenever the step would reach or pass it rules out overshoot and wrap.
    land     = (step_q == '0) || (step_w >= abs_w);

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          target_d = i_target;
          step_d   = i_step;
          state_d  = StRamp;
        end
      end
      StRamp: begin
        if (tick) begin
          if (land) begin
            duty_d  = target_q;
            state_d = StIdle;
          end else if (!diff[NB]) begin
            duty_d = duty_q + step_n;
          end else begin
            duty_d = duty_q - step_n;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      step_q   <= '0;
      duty_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      step_q   <= step_d;
      duty_q   <= duty_d;
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_busy      = (state_q == StRamp);
  assign o_dutyCycle = duty_q;
  assign o_tick      = tick;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp at 4-bit duty / 4-bit step (16-clock period).
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_target = '0;
  logic [3:0] i_step = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] o_duty;
  logic       o_busy;
  logic       o_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(
    ._NUM_BIT   (4),
    ._STEP_BITS (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_target    (i_target),
    .i_step      (i_step),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_dutyCycle (o_duty),
    .o_busy      (o_busy),
    .o_tick      (o_tick)
  );

  typedef struct {
    logic [3:0]      target;
    logic [3:0]      step;
    int              n;
    logic [3:0][3:0] exp;  // exp[0] is the value after the first tick
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance negedge by negedge until o_tick is seen, watching that the duty holds meanwhile.
  task automatic wait_tick(input string name, input logic [3:0] hold);
    bit ok;
    bit held;
    ok   = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_duty !== hold) held = 1'b0;
      if (o_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_tick_seen"}, 32'(ok), 32'd1);
    check({name, "_hold"}, 32'(held), 32'd1);
  endtask

  // Number of clocks until o_tick is next high, starting from the current negedge.
  task automatic clocks_to_tick(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (o_tick === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [3:0] s);
    i_target = t;
    i_step   = s;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    check("accept_busy", 32'(o_busy), 32'd1);
    check("accept_ready", 32'(o_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{target: 4'd10, step: 4'd3, n: 4, exp: {4'd10, 4'd9, 4'd6, 4'd3}};
    vecs[1] = '{target: 4'd1,  step: 4'd4, n: 3, exp: {4'd0, 4'd1, 4'd2, 4'd6}};
    vecs[2] = '{target: 4'd12, step: 4'd0, n: 1, exp: {4'd0, 4'd0, 4'd0, 4'd12}};
    vecs[3] = '{target: 4'd14, step: 4'd0, n: 1, exp: {4'd0, 4'd0, 4'd0, 4'd14}};
    vecs[4] = '{target: 4'd15, step: 4'd7, n: 1, exp: {4'd0, 4'd0, 4'd0, 4'd15}};
    vecs[5] = '{target: 4'd15, step: 4'd3, n: 1, exp: {4'd0, 4'd0, 4'd0, 4'd15}};
    vecs[6] = '{target: 4'd0,  step: 4'd0, n: 1, exp: {4'd0, 4'd0, 4'd0, 4'd0}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_duty", 32'(o_duty), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_tick", 32'(o_tick), 32'd0);
    rst = 1'b0;

    // Tick phase: first on clock 15, then every 16.
    clocks_to_tick(k);
    check("first_tick_clock", 32'(k), 32'd15);
    clocks_to_tick(k);
    check("tick_period", 32'(k), 32'd16);

    // Table-driven ramps, each starting from where the previous one left the duty.
    foreach (vecs[v]) begin
      if (o_tick === 1'b1) @(negedge clk);
      send(vecs[v].target, vecs[v].step);
      for (int j = 0; j < vecs[v].n; j++) begin
        wait_tick($sformatf("vec%0d_step%0d", v, j), o_duty);
        @(negedge clk);
        check($sformatf("vec%0d_duty%0d", v, j), 32'(o_duty), 32'(vecs[v].exp[j]));
        check($sformatf("vec%0d_busy%0d", v, j), 32'(o_busy),
              (j == vecs[v].n - 1) ? 32'd0 : 32'd1);
      end
      check($sformatf("vec%0d_ready_end", v), 32'(o_ready), 32'd1);
    end

    // Request during a ramp is ignored; asynchronous reset aborts mid-period.
    if (o_tick === 1'b1) @(negedge clk);
    send(4'd15, 4'd2);
    wait_tick("ign_a", o_duty);
    @(negedge clk);
    check("ign_duty_2", 32'(o_duty), 32'd2);
    repeat (3) @(negedge clk);
    i_target = 4'd0;
    i_step   = 4'd0;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    check("ign_busy", 32'(o_busy), 32'd1);
    check("ign_ready", 32'(o_ready), 32'd0);
    wait_tick("ign_b", o_duty);
    @(negedge clk);
    check("ign_duty_4", 32'(o_duty), 32'd4);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_duty", 32'(o_duty), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_tick", 32'(o_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clocks_to_tick(k);
    check("arst_first_tick_clock", 32'(k), 32'd15);

    // Acceptance in the tick cycle: no change at that tick, target lands on the next.
    check("acc_tick_high", 32'(o_tick), 32'd1);
    i_target = 4'd5;
    i_step   = 4'd5;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    check("acc_busy", 32'(o_busy), 32'd1);
    check("acc_duty_unchanged", 32'(o_duty), 32'd0);
    wait_tick("acc", o_duty);
    @(negedge clk);
    check("acc_duty_5", 32'(o_duty), 32'd5);
    check("acc_done_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream feeder for the PWM stage. Accepts a new duty-cycle setpoint through a valid/ready handshake.
- Slews its duty-cycle output toward that setpoint by a programmable step, changing at most once per PWM period.
- Every change takes effect exactly at a PWM period boundary. This gives glitch-free, rate-limited amplitude and offset control of the DDS analog path.
- o_dutyCycle connects directly to the PWM stage's duty-cycle input; the widths match.

Parameters:
- _NUM_BIT, 12: duty-cycle resolution. PWM period is 2^_NUM_BIT clocks.
- _STEP_BITS, 8: width of the per-period step input.

Ports:
- i_clk  in  1  system clock, shared with the PWM stage
- i_rst  in  1  asynchronous active-high reset
- i_target  in  _NUM_BIT  requested final duty cycle
- i_step  in  _STEP_BITS  maximum change per period; 0 means jump directly
- i_valid  in  1  i_target and i_step are valid
- o_ready  out  1  block can accept a new request
- o_dutyCycle  out  _NUM_BIT  current duty cycle, registered
- o_busy  out  1  ramp in progress
- o_tick  out  1  one-cycle pulse on the last clock of each PWM period

Behaviour:
- Reset (asynchronous, active-high) forces: o_dutyCycle=0, o_busy=0, o_ready=1, o_tick=0, period counter=0, state IDLE, latched target/step=0.
- Period counter: _NUM_BIT bits, free-running, wraps at all-ones.
  - o_tick=1 exactly when the counter is all-ones, registered, so the first tick falls on clock 2^_NUM_BIT-1 after reset release.
  - A duty update on a tick cycle becomes visible when the counter reads 0, i.e. at the start of the next PWM period.
- States: IDLE, RAMP.
  - IDLE: o_ready=1, o_busy=0.
    - When i_valid && o_ready: latch i_target and i_step, enter RAMP.
    - o_ready falls and o_busy rises on the next clock.
    - A tick in the acceptance cycle does not change o_dutyCycle.
  - RAMP: o_ready=0, o_busy=1. i_valid is ignored; there is no queuing.
    - On each tick, compute diff = target - duty in _NUM_BIT+1 signed bits.
    - If step==0 or |diff| <= step: duty <= target, go to IDLE.
    - Otherwise: duty <= duty + step when diff>0, duty - step when diff<0.
    - No tick means no change.
- Target equal to current duty: enter RAMP anyway; complete at the next tick with no value change.
- Arithmetic rules:
  - Step is zero-extended to _NUM_BIT+1 bits.
  - The |diff| <= step test prevents overshoot, underflow below 0 and overflow above 2^_NUM_BIT-1. o_dutyCycle never wraps.
  - If _STEP_BITS > _NUM_BIT, any step >= |diff| simply lands on target.
- Latency:
  - First duty change occurs on the first tick after acceptance, i.e. up to 2^_NUM_BIT clocks later.
  - Completion takes ceil(|diff|/step) ticks; 1 tick when step=0.
- Reset mid-ramp: immediate abort, all outputs to reset values. The latched request is discarded.

Decomposition:
- Shared package pwm_pkg holds:
  - state encoding IDLE/RAMP
  - default widths NUM_BIT=12, STEP_BITS=8
  - constant PERIOD_MAX = 2^NUM_BIT-1
- Sub-module pwm_period_timer: the counter plus registered o_tick, with i_clk/i_rst. It can later be shared with the PWM stage to guarantee phase alignment.

Test Plan (_NUM_BIT=4, _STEP_BITS=4, period 16 clocks):
- Reset release -> o_dutyCycle=0, o_ready=1, o_busy=0; o_tick first high on clock 15, then every 16 clocks.
- From 0, target=10, step=3 -> o_dutyCycle 3,6,9,10 on four successive ticks. o_busy falls and o_ready rises after the 4th; no value changes between ticks.
- From 10, target=1, step=4 -> 6,2,1 on three ticks; never below 1.
- From 1, target=12, step=0 -> 12 at the first tick, then IDLE. From 14, target=15, step=7 -> 15, no wrap to 5.
- During the ramp 0->15 step=2, pulse i_valid with target=0 -> ignored, ramp continues 2,4,... Assert i_rst asynchronously mid-period -> o_dutyCycle=0, o_ready=1 immediately, counter restarts at 0.
- i_valid asserted in the same cycle as o_tick while IDLE (target=5, step=5, duty 0) -> accepted; no change at that tick; 5 appears at the next tick.
